demux1_8_scan: RTL

DEMUX1_8_SCAN -- requirements
Module: demux1_8_scan

---
 rtl/demux_pkg.sv | 19 +
 rtl/scan_ctr.sv | 20 ++
 rtl/demux1_8_scan.sv | 97 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared sizing, FSM state type and helpers for the 1-to-8 scan demultiplexer.
// Parity support in the top level is enabled with DEMUX_PARITY_EN.
package demux_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SELW  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [SELW-1:0] LAST_PTR = SELW'(WIDTH - 1);

  function automatic logic word_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/scan_ctr.sv
// Scan bit pointer: free-running 3-bit counter with synchronous clear and
// enable; wraps 7 -> 0 naturally.
module scan_ctr
  import demux_pkg::*;
(
  input  logic            clk,
  input  logic            clr,
  input  logic            en,
  output logic [SELW-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/demux1_8_scan.sv
// Serial 1-to-8 demultiplexer with manual (sel-addressed) and scan (pointer)
// modes. Defining DEMUX_PARITY_EN adds the registered frame parity output par.
module demux1_8_scan
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic [SELW-1:0]  sel,
  input  logic             load,
  input  logic             auto,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             frame_valid
`ifdef DEMUX_PARITY_EN
  ,
  output logic             par
`endif
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] dout_next;
  logic [SELW-1:0]  ptr;
  logic             ptr_en;
  logic             abort;
  logic             frame_done;

  // The pointer is always 0 in IDLE, so entering SCAN only needs an increment.
  scan_ctr u_scan_ctr (
    .clk (clk),
    .clr (rst | abort),
    .en  (ptr_en),
    .q   (ptr)
  );

  always_comb begin
    state_next = state;
    dout_next  = dout;
    ptr_en     = 1'b0;
    abort      = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          if (auto) begin
            dout_next[0] = din;
            ptr_en       = 1'b1;
            state_next   = SCAN;
          end else begin
            dout_next[sel] = din;
          end
        end
      end
      SCAN: begin
        if (!auto) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (load) begin
          dout_next[ptr] = din;
          ptr_en         = 1'b1;
          if (ptr == LAST_PTR) begin
            frame_done = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // busy tracks the next state so it stays a pure register output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      dout        <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_next;
      dout        <= dout_next;
      busy        <= (state_next == SCAN);
      frame_valid <= frame_done;
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par <= 1'b0;
    end else if (frame_done) begin
      par <= word_parity(dout_next);
    end
  end
`endif

endmodule
